dm_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-ported data memory (DM).
- Shares the DM between port 0 (CPU load/store unit) and port 1 (AHB slave / DMA side).
- Generates the DM enable/write/address/data strobes and forwards the DM stall and read-data handshake to the granted port.
- Stalls the losing port until it is served.

---
 rtl/dm_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-ported data memory.
// Define DM_ARB_STATS_EN to add per-port completion and conflict counters.
module dm_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_enable,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_stall,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_enable,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_stall,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  dm_enable,
  output logic                  dm_write,
  output logic [ADDR_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_in,
  input  logic                  dm_stall,
  input  logic [DATA_WIDTH-1:0] dm_out
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0]           p0_count,
  output logic [31:0]           p1_count,
  output logic [31:0]           conflict_count
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t        state;
  logic          last_grant;  // port that completed most recently
  logic [CW-1:0] drain_cnt;
  logic          done0, done1;

  assign done0 = (state == GRANT0) && p0_enable && !dm_stall;
  assign done1 = (state == GRANT1) && p1_enable && !dm_stall;

  // Read data fans out to both ports; only the granted port's done cycle matters.
  assign p0_rdata = dm_out;
  assign p1_rdata = dm_out;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    dm_enable  = 1'b0;
    dm_write   = 1'b0;
    dm_address = '0;
    dm_in      = '0;
    p0_stall   = p0_enable;
    p1_stall   = p1_enable;
    case (state)
      GRANT0: begin
        dm_enable  = p0_enable;
        dm_write   = p0_enable & p0_write;
        dm_address = p0_address;
        dm_in      = p0_wdata;
        p0_stall   = dm_stall;
      end
      GRANT1: begin
        dm_enable  = p1_enable;
        dm_write   = p1_enable & p1_write;
        dm_address = p1_address;
        dm_in      = p1_wdata;
        p1_stall   = dm_stall;
      end
      default: ;
    endcase
  end

  // NOTE: reset is synchronous here; the DM shares it, so no drain is needed after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_enable && p1_enable) state <= last_grant ? GRANT0 : GRANT1;
          else if (p0_enable)         state <= GRANT0;
          else if (p1_enable)         state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if ((state == GRANT0) ? !p0_enable : !p1_enable) begin
            // Abort: the DM's internal sequence needs time to settle before reuse.
            drain_cnt <= CW'(DRAIN_CYCLES);
            state     <= (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
          end else if (!dm_stall) begin
            last_grant <= (state == GRANT1);
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt <= CW'(1)) state <= IDLE;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_count       <= '0;
      p1_count       <= '0;
      conflict_count <= '0;
    end else begin
      if (done0 && p0_count != '1) p0_count <= p0_count + 32'd1;
      if (done1 && p1_count != '1) p1_count <= p1_count + 32'd1;
      if (state == IDLE && p0_enable && p1_enable && conflict_count != '1)
        conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule
